seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed display driver downstream of the two per-player `Decoder` instances in the chess-clock top level. It takes the eight 7-segment codes (player 1 and player 2, four digits each) and scans them one digit at a time onto a single shared segment bus with one-hot digit enables. It inserts a one-cycle blanking gap between digits to suppress ghosting, and blinks a player's four digits while that player's `OVERFLOW` flag is high.

## Interface
Parameters:
- `REFRESH_DIV`, default 1000: CE-qualified cycles per digit slot; must be ≥ 2.
- `BLINK_DIV`, default 64: full scan frames per blink half-period; must be ≥ 1.

Ports:
- `CLK` in 1: system clock; all state changes on its rising edge.
- `CLR` in 1: asynchronous, active-low reset.
- `CE` in 1: clock enable; all counters and state advance only when high.
- `seg0_0`..`seg0_3` in 7 each: player 1 segment codes, digits 0–3, active-low segments.
- `seg1_0`..`seg1_3` in 7 each: player 2 segment codes, digits 0–3, active-low segments.
- `OVERFLOW1` in 1: player 1 time expired; enables blinking of digits 0–3.
- `OVERFLOW2` in 1: player 2 time expired; enables blinking of digits 4–7.
- `SEG` out 7: shared segment bus, active-low, registered.
- `DP` out 1: separator dot, active-low, registered.
- `AN` out 8: digit enables, active-low, one-hot or all-high, registered.

## Operation
- Digit index `idx` (3 bits) maps as follows:
  - 0–3 → `seg0_0`..`seg0_3`, driven on `AN[0]`..`AN[3]`.
  - 4–7 → `seg1_0`..`seg1_3`, driven on `AN[4]`..`AN[7]`.
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1 on every CE cycle. The tick fires when `cnt`=`REFRESH_DIV`-1 and `CE`=1; `cnt` then wraps to 0.
- Two-state FSM: BLANK and SHOW.
  - In SHOW, a tick moves to BLANK: `AN`=8'hFF, `SEG`=7'h7F, `DP`=1, and `idx` increments, wrapping 7→0.
  - In BLANK, the next CE cycle moves to SHOW unconditionally: `SEG` loads the code selected by `idx`, `AN[idx]`=0 with all other bits 1, and `DP`=0 only if `idx` is 1 or 5, else 1.
- Input codes are sampled only on the BLANK→SHOW edge and held for the whole slot. Input changes mid-slot have no effect until that digit's next slot.
- Blink logic:
  - Frame counter `frm` increments when `idx` wraps 7→0.
  - When `frm`=`BLINK_DIV`-1 at the wrap, `phase` toggles and `frm` clears.
  - At the BLANK→SHOW load:
    - If `idx`<4 and `OVERFLOW1`=1 and `phase`=1, `AN` stays 8'hFF and `SEG`=7'h7F.
    - The same rule applies to `idx`≥4 with `OVERFLOW2`.
  - The overflow flags are sampled at slot load only.
- With `CE`=0, every register holds, including outputs and counters.
- Reset, `CLR`=0, asynchronously forces:
  - `AN`=8'hFF, `SEG`=7'h7F, `DP`=1.
  - `idx`=0, `cnt`=0, `frm`=0, `phase`=0, state=BLANK.
  - Reset mid-slot therefore blanks the display immediately. Release takes effect on the next rising edge.

## Timing
- Number CE-qualified edges after reset release 1, 2, 3, …
  - Edge 1: SHOW, digit 0.
  - Digit n is driven on edges n·R+1 through (n+1)·R-1, where R=`REFRESH_DIV`.
  - Edge (n+1)·R is the blank.
  - Per-digit duty: (R-1)/R. Frame length: 8·R CE cycles.
- Latency from input code to `SEG`: 0–8·R CE cycles, depending on scan position. It is exactly one edge after the BLANK state of that digit.
- `phase` is 0 for frames 0..`BLINK_DIV`-1, 1 for the next `BLINK_DIV` frames, and so on.
- Simultaneous `OVERFLOW1` and `OVERFLOW2`: both halves blink in unison, sharing the same `phase`.
- `SEG`, `DP` and `AN` always change on the same edge; no output depends combinationally on an input.

## Test plan
- Reset: pulse `CLR`=0 mid-slot without a clock edge → `AN`=8'hFF, `SEG`=7'h7F, `DP`=1 immediately. After release with `CE`=1, edge 1 gives `AN`=8'hFE.
- Scan order (R=4, `CE`=1, codes 7'h01..7'h08 on digits 0–7):
  - Edges 1–3: `AN`=8'hFE, `SEG`=7'h01.
  - Edge 4: `AN`=8'hFF.
  - Edges 5–7: `AN`=8'hFD, `SEG`=7'h02, `DP`=0.
  - Edge 33: `AN`=8'hFE again.
- Input hold: change `seg0_0` to 7'h40 at edge 2 → `SEG` stays 7'h01 through edge 3. It shows 7'h40 from edge 33.
- CE gating: hold `CE`=0 for 10 cycles after edge 2 → all outputs frozen. After resume, the blank arrives exactly 2 CE edges later.
- Blink (R=4, `BLINK_DIV`=2, `OVERFLOW1`=1):
  - Frames 0–1 scan all digits normally.
  - Frames 2–3: `AN[3:0]` stay high while `AN[7:4]` scan normally.
  - Frame 4: normal again.
  - Drop `OVERFLOW1` during frame 2 → the next player 1 slot lights.
- DP / both overflow: `DP`=0 only during slots 1 and 5. With `OVERFLOW1`=`OVERFLOW2`=1 and `phase`=1, `AN`=8'hFF for the entire frame.

Source files
------------

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Purpose:
//   Time-multiplexed 8-digit 7-segment driver for the chess clock. Scans the
//   four player-1 digits and four player-2 digits one at a time onto a shared
//   segment bus. A one-cycle blanking slot separates digits to suppress
//   ghosting. A player's digits blink while that player's overflow flag is
//   set.
//
// Parameters:
//   REFRESH_DIV : CE-qualified cycles per digit slot (>= 2)
//   BLINK_DIV   : full scan frames per blink half-period (>= 1)
//
// Ports:
//   CLK              in  1  system clock, rising edge
//   CLR              in  1  asynchronous active-low reset
//   CE               in  1  clock enable; all state advances only when high
//   seg0_0..seg0_3   in  7  player 1 segment codes (active-low)
//   seg1_0..seg1_3   in  7  player 2 segment codes (active-low)
//   OVERFLOW1        in  1  player 1 expired -> blink digits 0..3
//   OVERFLOW2        in  1  player 2 expired -> blink digits 4..7
//   SEG              out 7  shared segment bus, active-low, registered
//   DP               out 1  separator dot, active-low, registered
//   AN               out 8  digit enables, active-low, registered
// ---------------------------------------------------------------------------
module seg_scan_mux #(
   parameter int REFRESH_DIV = 1000,
   parameter int BLINK_DIV   = 64
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       CE,
   input  logic [6:0] seg0_0,
   input  logic [6:0] seg0_1,
   input  logic [6:0] seg0_2,
   input  logic [6:0] seg0_3,
   input  logic [6:0] seg1_0,
   input  logic [6:0] seg1_1,
   input  logic [6:0] seg1_2,
   input  logic [6:0] seg1_3,
   input  logic       OVERFLOW1,
   input  logic       OVERFLOW2,
   output logic [6:0] SEG,
   output logic       DP,
   output logic [7:0] AN
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_idx;
   logic [2:0]         w_idx_next;
   logic [FRM_W-1:0]   r_frm;
   logic [FRM_W-1:0]   w_frm_next;
   logic               r_phase;
   logic               w_phase_next;
   logic [6:0]         r_seg;
   logic [6:0]         w_seg_next;
   logic               r_dp;
   logic               w_dp_next;
   logic [7:0]         r_an;
   logic [7:0]         w_an_next;

   logic               w_tick;
   logic [6:0]         w_codes [8];
   logic               w_ovf_sel;
   logic               w_dark;

   assign w_codes[0] = seg0_0;
   assign w_codes[1] = seg0_1;
   assign w_codes[2] = seg0_2;
   assign w_codes[3] = seg0_3;
   assign w_codes[4] = seg1_0;
   assign w_codes[5] = seg1_1;
   assign w_codes[6] = seg1_2;
   assign w_codes[7] = seg1_3;

   // End of a digit slot; the slot counter free-runs so BLANK always falls
   // on the last count of each R-cycle period.
   assign w_tick    = (r_cnt == CNT_W'(REFRESH_DIV - 1));

   // idx[2] splits the display into the player-1 and player-2 halves.
   assign w_ovf_sel = r_idx[2] ? OVERFLOW2 : OVERFLOW1;
   assign w_dark    = w_ovf_sel & r_phase;

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_frm_next   = r_frm;
      w_phase_next = r_phase;
      w_seg_next   = r_seg;
      w_dp_next    = r_dp;
      w_an_next    = r_an;

      case (r_state)
         ST_SHOW: begin
            if (w_tick) begin
               w_state_next = ST_BLANK;
               w_an_next    = 8'hFF;
               w_seg_next   = 7'h7F;
               w_dp_next    = 1'b1;
               w_idx_next   = r_idx + 3'd1;
               // Leaving the last digit closes a full frame.
               if (r_idx == 3'd7) begin
                  if (r_frm == FRM_W'(BLINK_DIV - 1)) begin
                     w_frm_next   = '0;
                     w_phase_next = ~r_phase;
                  end else begin
                     w_frm_next = r_frm + FRM_W'(1);
                  end
               end
            end
         end
         default: begin // ST_BLANK
            w_state_next = ST_SHOW;
            if (w_dark) begin
               // Blinked-off slot: digit and its dot stay dark.
               w_an_next  = 8'hFF;
               w_seg_next = 7'h7F;
               w_dp_next  = 1'b1;
            end else begin
               w_an_next  = ~(8'd1 << r_idx);
               w_seg_next = w_codes[r_idx];
               w_dp_next  = !((r_idx == 3'd1) || (r_idx == 3'd5));
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_frm   <= '0;
         r_phase <= 1'b0;
         r_seg   <= 7'h7F;
         r_dp    <= 1'b1;
         r_an    <= 8'hFF;
      end else if (CE) begin
         r_state <= w_state_next;
         r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
         r_idx   <= w_idx_next;
         r_frm   <= w_frm_next;
         r_phase <= w_phase_next;
         r_seg   <= w_seg_next;
         r_dp    <= w_dp_next;
         r_an    <= w_an_next;
      end
   end

   assign SEG = r_seg;
   assign DP  = r_dp;
   assign AN  = r_an;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Scoreboard bench for seg_scan_mux with REFRESH_DIV=4, BLINK_DIV=2.
// The driver issues one clock per step and pushes the expected outputs for
// that edge; a monitor pops and compares one entry per rising edge.
// Expected values come from the edge-number timing formula: digit n is shown
// on edges n*R+1 .. (n+1)*R-1, edge (n+1)*R is blank, frame = edge/R/8,
// blink phase = (frame/BLINK_DIV) mod 2.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;

   localparam int R  = 4;
   localparam int BD = 2;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      bit         chk_dp;
      int         id;
   } exp_t;

   logic       clk   = 1'b0;
   logic       clr_n = 1'b0;
   logic       ce    = 1'b0;
   logic [6:0] codes [8];
   logic       ov1   = 1'b0;
   logic       ov2   = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;

   exp_t       q [$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         e_cnt    = 0;
   int         step_id  = 0;
   logic [6:0] held_code = 7'h7F;
   bit         held_dark = 1'b0;
   exp_t       last_exp;

   always #5 clk = ~clk;

   seg_scan_mux #(
      .REFRESH_DIV(R),
      .BLINK_DIV  (BD)
   ) dut (
      .CLK      (clk),
      .CLR      (clr_n),
      .CE       (ce),
      .seg0_0   (codes[0]),
      .seg0_1   (codes[1]),
      .seg0_2   (codes[2]),
      .seg0_3   (codes[3]),
      .seg1_0   (codes[4]),
      .seg1_1   (codes[5]),
      .seg1_2   (codes[6]),
      .seg1_3   (codes[7]),
      .OVERFLOW1(ov1),
      .OVERFLOW2(ov2),
      .SEG      (seg),
      .DP       (dp),
      .AN       (an)
   );

   task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
      end
   endtask

   function automatic exp_t blank_exp();
      exp_t x;
      x.an     = 8'hFF;
      x.seg    = 7'h7F;
      x.dp     = 1'b1;
      x.chk_dp = 1'b1;
      x.id     = 0;
      return x;
   endfunction

   // One clock: inputs change on the falling edge, expectation is queued,
   // then the rising edge happens. Returns 2 time units after the edge.
   task automatic step(input logic ce_v);
      exp_t x;
      int   e, n, f, ph;
      @(negedge clk);
      ce = ce_v;
      if (ce_v) begin
         e_cnt++;
         e = e_cnt;
         if ((e % R) == 0) begin
            x = blank_exp();
         end else begin
            n  = (e / R) % 8;
            f  = (e / R) / 8;
            ph = (f / BD) % 2;
            if ((e % R) == 1) begin
               held_code = codes[n];
               held_dark = (((n < 4) ? ov1 : ov2) == 1'b1) && (ph == 1);
            end
            if (held_dark) begin
               x        = blank_exp();
               x.chk_dp = 1'b0;
            end else begin
               x.an     = ~(8'd1 << n);
               x.seg    = held_code;
               x.dp     = !((n == 1) || (n == 5));
               x.chk_dp = 1'b1;
            end
         end
         last_exp = x;
      end else begin
         x = last_exp;
      end
      step_id++;
      x.id = step_id;
      q.push_back(x);
      $display("step %0d ce=%0b edge=%0d exp AN=%h SEG=%h DP=%0b",
               step_id, ce_v, e_cnt, x.an, x.seg, x.dp);
      @(posedge clk);
      #2;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      @(negedge clk);
      ce = 1'b0;
      #1 clr_n = 1'b0;
      #1;
      chk("rst_an", 0, an, 8'hFF);
      chk("rst_seg", 0, {1'b0, seg}, 8'h7F);
      chk("rst_dp", 0, {7'd0, dp}, 8'h01);
      #1 clr_n = 1'b1;
      e_cnt     = 0;
      held_dark = 1'b0;
      last_exp  = blank_exp();
   endtask

   // Monitor: one comparison set per rising edge that has a queued entry.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("an", x.id, an, x.an);
            chk("seg", x.id, {1'b0, seg}, {1'b0, x.seg});
            if (x.chk_dp) chk("dp", x.id, {7'd0, dp}, {7'd0, x.dp});
         end
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) codes[i] = 7'(i + 1);
      last_exp = blank_exp();

      // Power-on reset, released between edges.
      repeat (2) @(posedge clk);
      #2;
      chk("por_an", 0, an, 8'hFF);
      chk("por_seg", 0, {1'b0, seg}, 8'h7F);
      chk("por_dp", 0, {7'd0, dp}, 8'h01);
      @(negedge clk);
      #1 clr_n = 1'b1;

      // Run A: scan order, CE freeze, input hold, player-1 blink.
      ov1 = 1'b1;
      step(1'b1);
      step(1'b1);
      repeat (10) step(1'b0);
      codes[0] = 7'h40;
      repeat (159) step(1'b1);

      // Mid-slot reset (digit 0 is lit here).
      do_reset();

      // Run B: drop OVERFLOW1 during the first blinking frame.
      codes[0] = 7'h01;
      ov1 = 1'b1;
      repeat (70) step(1'b1);
      ov1 = 1'b0;
      repeat (30) step(1'b1);

      do_reset();

      // Run C: both players blinking in unison.
      ov1 = 1'b1;
      ov2 = 1'b1;
      repeat (100) step(1'b1);

      @(negedge clk);
      chk("queue_drained", 0, 8'(q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
